// File: rtl/key_debounce_events.sv
// key_debounce_events: per-key synchroniser, debouncer and press/release/long/repeat event generator
//   i_sys_clk      system clock, rising edge
//   i_sys_rst_n    asynchronous active-low reset, synchronous release
//   i_key          raw asynchronous key pins (KEY_NUM)
//   o_key_level    debounced level, 1 = pressed
//   o_key_press    1-cycle pulse on accepted press
//   o_key_release  1-cycle pulse on accepted release
//   o_key_long     1-cycle pulse when a hold reaches LONG_CYCLES
//   o_key_repeat   1-cycle pulse every REPEAT_CYCLES while held after long
module key_debounce_events #(
  parameter int KEY_NUM       = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst_n,
  input  logic [KEY_NUM-1:0] i_key,
  output logic [KEY_NUM-1:0] o_key_level,
  output logic [KEY_NUM-1:0] o_key_press,
  output logic [KEY_NUM-1:0] o_key_release,
  output logic [KEY_NUM-1:0] o_key_long,
  output logic [KEY_NUM-1:0] o_key_repeat
);
  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
  localparam logic [KEY_NUM-1:0] REL_PIN = (ACTIVE_LOW != 0) ? '1 : '0;
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  logic [KEY_NUM-1:0] sync1, sync2, s;
  // Synchroniser presets to the released pin level so reset never fakes a press.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      sync1 <= REL_PIN;
      sync2 <= REL_PIN;
    end else begin
      sync1 <= i_key;
      sync2 <= sync1;
    end
  end
  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold, hold_nx;
    state_t state, state_nx;
    logic level, press, rel, long_p, rpt_p;
    logic flip, rise, fall, long_nx, rpt_nx;
    // The change is accepted on the cycle the count would reach DB_CYCLES.
    assign flip = (s[k] != level) && (db_cnt == DW'(DB_CYCLES - 1));
    assign rise = flip & s[k];
    assign fall = flip & ~s[k];
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
        db_cnt <= '0;
        level  <= 1'b0;
        press  <= 1'b0;
        rel    <= 1'b0;
        long_p <= 1'b0;
        rpt_p  <= 1'b0;
        state  <= IDLE;
        hold   <= '0;
      end else begin
        db_cnt <= (s[k] != level && !flip) ? db_cnt + 1'b1 : '0;
        level  <= level ^ flip;
        press  <= rise;
        rel    <= fall;
        long_p <= long_nx;
        rpt_p  <= rpt_nx;
        state  <= state_nx;
        hold   <= hold_nx;
      end
    end
    // Release takes priority over a long/repeat falling due in the same cycle.
    always_comb begin
      state_nx = state;
      hold_nx  = hold;
      long_nx  = 1'b0;
      rpt_nx   = 1'b0;
      case (state)
        IDLE: if (rise) begin
          state_nx = PRESSED;
          hold_nx  = '0;
        end
        PRESSED: if (fall) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (LONG_CYCLES != 0) begin
          if (hold == HW'(LONG_CYCLES - 1)) begin
            long_nx  = 1'b1;
            hold_nx  = '0;
            state_nx = HELD;
          end else hold_nx = hold + 1'b1;
        end
        HELD: if (fall) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (REPEAT_CYCLES != 0) begin
          if (hold == HW'(REPEAT_CYCLES - 1)) begin
            rpt_nx  = 1'b1;
            hold_nx = '0;
          end else hold_nx = hold + 1'b1;
        end
        default: begin
          state_nx = IDLE;
          hold_nx  = '0;
        end
      endcase
    end
    assign o_key_level[k]   = level;
    assign o_key_press[k]   = press;
    assign o_key_release[k] = rel;
    assign o_key_long[k]    = long_p;
    assign o_key_repeat[k]  = rpt_p;
  end
endmodule

// File: tb/tb_key_debounce_events.sv
// tb_key_debounce_events: directed + random checks of key_debounce_events against a window/timestamp model
module tb_key_debounce_events;
  localparam int DB = 8, LG = 32, RP = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] level, press, rel, lng, rpt;
  int checks = 0, fails = 0, cyc = 0;
  logic [3:0] m1, m2, e_lvl, e_pr, e_rl, e_lg, e_rp;
  logic [DB-1:0] hist [4];
  bit held [4];
  int tp [4];

  key_debounce_events #(.KEY_NUM(4), .ACTIVE_LOW(1), .DB_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_key(key), .o_key_level(level), .o_key_press(press),
    .o_key_release(rel), .o_key_long(lng), .o_key_repeat(rpt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic model_reset();
    m1 = '1; m2 = '1;
    e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
    for (int k = 0; k < 4; k++) begin
      hist[k] = '0;
      held[k] = 0;
      tp[k]   = 0;
    end
  endtask

  // Level changes when the last DB synchronised samples all disagree with it;
  // long/repeat are timestamps measured from the press.
  task automatic model_edge(input logic [3:0] pins);
    cyc++;
    for (int k = 0; k < 4; k++) begin
      logic sv, fl;
      int d;
      sv = ~m2[k];
      hist[k] = {hist[k][DB-2:0], sv};
      fl = (hist[k] == {DB{~e_lvl[k]}});
      e_pr[k] = fl & sv;
      e_rl[k] = fl & ~sv;
      e_lg[k] = 1'b0;
      e_rp[k] = 1'b0;
      if (fl) e_lvl[k] = sv;
      if (e_pr[k]) begin
        held[k] = 1;
        tp[k] = cyc;
      end else if (e_rl[k]) held[k] = 0;
      else if (held[k]) begin
        d = cyc - tp[k];
        e_lg[k] = (d == LG);
        e_rp[k] = (d > LG) && ((d - LG) % RP == 0);
      end
    end
    m2 = m1;
    m1 = pins;
  endtask

  task automatic tick(input logic [3:0] pins);
    key = pins;
    @(posedge clk);
    model_edge(pins);
    #1;
    chk("level", level, e_lvl);
    chk("press", press, e_pr);
    chk("release", rel, e_rl);
    chk("long", lng, e_lg);
    chk("repeat", rpt, e_rp);
  endtask

  initial begin
    int pc, lc, cnt, nrel, acc;
    int rq[$];
    bit saw;
    int rem [4];
    logic [3:0] pins;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 4'h0);
    chk("rst_press", press, 4'h0);
    chk("rst_release", rel, 4'h0);
    chk("rst_long", lng, 4'h0);
    chk("rst_repeat", rpt, 4'h0);
    rst_n = 1'b1;
    repeat (3) tick(4'hF);
    pc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(4'hE);
      if (press[0] && pc < 0) pc = i;
    end
    chk_rng("k0_press_latency", pc, 9, 11);
    chk("k0_level_held", {3'b000, level[0]}, 4'h1);
    repeat (20) tick(4'hF);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick(4'hD);
      acc |= int'(press[1] | rel[1] | lng[1] | rpt[1] | level[1]);
    end
    for (int i = 0; i < 20; i++) begin
      tick(4'hF);
      acc |= int'(press[1] | rel[1] | lng[1] | rpt[1] | level[1]);
    end
    chk_rng("k1_glitch_ignored", acc, 0, 0);
    cnt = 0;
    pc = -1;
    for (int i = 1; i <= 28; i++) begin
      tick((i <= 6 || i >= 9) ? 4'hB : 4'hF);
      if (press[2]) begin
        cnt++;
        pc = i;
      end
    end
    chk_rng("k2_bounce_press_count", cnt, 1, 1);
    chk_rng("k2_bounce_press_cycle", pc, 17, 19);
    repeat (15) tick(4'hF);
    pc = -1;
    for (int i = 0; i < 20 && pc < 0; i++) begin
      tick(4'h7);
      if (press[3]) pc = cyc;
    end
    chk_rng("k3_press_seen", pc, 0, 1 << 30);
    lc = -1;
    for (int i = 0; i < 100; i++) begin
      tick(4'h7);
      if (lng[3]) lc = cyc - pc;
      if (rpt[3]) rq.push_back(cyc - pc);
    end
    chk_rng("k3_long_offset", lc, LG, LG);
    chk_rng("k3_repeat_count", rq.size(), 4, 4);
    for (int i = 0; i < rq.size(); i++) chk_rng("k3_repeat_offset", rq[i], LG + RP * (i + 1), LG + RP * (i + 1));
    cnt = 0;
    nrel = 0;
    for (int i = 0; i < 40; i++) begin
      tick(4'hF);
      if (rpt[3] || lng[3]) cnt++;
      if (rel[3]) nrel++;
    end
    chk_rng("k3_release_pulses", nrel, 1, 1);
    chk_rng("k3_no_repeat_after_release", cnt, 0, 0);
    saw = 0;
    for (int i = 0; i < 45; i++) begin
      tick(4'hC);
      if (press == 4'b0011) saw = 1;
    end
    chk_rng("k01_same_cycle_press", int'(saw), 1, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", level, 4'h0);
    chk("midrst_press", press, 4'h0);
    chk("midrst_release", rel, 4'h0);
    chk("midrst_long", lng, 4'h0);
    chk("midrst_repeat", rpt, 4'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc = -1;
    lc = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(4'hC);
      if (press == 4'b0011 && pc < 0) pc = i;
      if (lng[0] && lc < 0) lc = i;
    end
    chk_rng("post_rst_press", pc, 9, 11);
    chk_rng("post_rst_long_offset", lc - pc, LG, LG);
    pins = 4'hF;
    for (int k = 0; k < 4; k++) rem[k] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          pins[k] = ~pins[k];
          rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90)) : int'($urandom_range(1, 12));
        end
        rem[k]--;
      end
      tick(pins);
    end
    repeat (20) tick(4'hF);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
